// File: rtl/screen_sequencer.sv
// Frame-synchronous game-screen sequencer: selects title / win / play image,
// inserts black blanking before every screen change, times win screens out.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   frame_start         1-cycle pulse at the start of each video frame
//   start_btn           debounced start level (rising edge used, TITLE only)
//   p1_win, p2_win      1-cycle win pulses (PLAY only, p1 has priority)
//   abort               level, return to title from any non-title state
//   screen_sel          00 title, 01 p1 win, 10 p2 win, 11 play
//   blank               1 = colorizer output forced black
//   game_active         1 while play screen is shown unblanked
module screen_sequencer #(
    parameter int BLANK_FRAMES = 4,
    parameter int HOLD_FRAMES  = 180,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       start_btn,
    input  logic       p1_win,
    input  logic       p2_win,
    input  logic       abort,
    output logic [1:0] screen_sel,
    output logic       blank,
    output logic       game_active
);

    typedef enum logic [2:0] {
        S_TITLE,
        S_PLAY,
        S_WIN1,
        S_WIN2,
        S_BLANK
    } state_t;

    state_t           state;
    state_t           tgt;
    state_t           go_tgt;
    state_t           commit_tgt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             start_q;
    logic             pend_start;
    logic             pend_w1;
    logic             pend_w2;
    logic             start_rise;
    logic             start_ev;
    logic             w1_ev;
    logic             w2_ev;
    logic             go_req;
    logic             do_commit;
    logic             do_blank;

    function automatic logic [1:0] enc(state_t s);
        logic [1:0] r;
        r = 2'b00;
        case (s)
            S_WIN1:  r = 2'b01;
            S_WIN2:  r = 2'b10;
            S_PLAY:  r = 2'b11;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    // Events arriving on the frame_start cycle itself are folded in here
    // so they act at that same frame boundary.
    always_comb begin
        start_rise = start_btn & ~start_q;
        start_ev   = pend_start | (start_rise & (state == S_TITLE));
        w1_ev      = pend_w1 | (p1_win & (state == S_PLAY));
        w2_ev      = pend_w2 | (p2_win & (state == S_PLAY));
        cnt_inc    = cnt + 1'b1;
        go_req     = 1'b0;
        go_tgt     = S_TITLE;
        if (abort && state != S_TITLE && state != S_BLANK) begin
            go_req = 1'b1;
            go_tgt = S_TITLE;
        end else begin
            case (state)
                S_TITLE: begin
                    if (start_ev) begin
                        go_req = 1'b1;
                        go_tgt = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (w1_ev) begin
                        go_req = 1'b1;
                        go_tgt = S_WIN1;
                    end else if (w2_ev) begin
                        go_req = 1'b1;
                        go_tgt = S_WIN2;
                    end
                end
                S_WIN1, S_WIN2: begin
                    if (cnt_inc == CNT_W'(HOLD_FRAMES)) begin
                        go_req = 1'b1;
                        go_tgt = S_TITLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Commit/blank decision; abort inside BLANK only retargets to title,
    // the remaining blank count keeps running.
    always_comb begin
        do_commit  = 1'b0;
        do_blank   = 1'b0;
        commit_tgt = go_tgt;
        if (state == S_BLANK) begin
            commit_tgt = abort ? S_TITLE : tgt;
            do_commit  = (cnt < CNT_W'(2));
        end else if (go_req) begin
            if (BLANK_FRAMES == 0) begin
                do_commit = 1'b1;
            end else begin
                do_blank = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_TITLE;
            tgt         <= S_TITLE;
            cnt         <= '0;
            start_q     <= 1'b0;
            pend_start  <= 1'b0;
            pend_w1     <= 1'b0;
            pend_w2     <= 1'b0;
            screen_sel  <= 2'b00;
            blank       <= 1'b0;
            game_active <= 1'b0;
        end else begin
            start_q <= start_btn;
            if (frame_start) begin
                pend_start <= 1'b0;
                pend_w1    <= 1'b0;
                pend_w2    <= 1'b0;
                if (do_commit) begin
                    state       <= commit_tgt;
                    tgt         <= commit_tgt;
                    screen_sel  <= enc(commit_tgt);
                    blank       <= 1'b0;
                    game_active <= (commit_tgt == S_PLAY);
                    cnt         <= '0;
                end else if (do_blank) begin
                    state       <= S_BLANK;
                    tgt         <= go_tgt;
                    cnt         <= CNT_W'(BLANK_FRAMES);
                    blank       <= 1'b1;
                    game_active <= 1'b0;
                end else if (state == S_BLANK) begin
                    tgt <= commit_tgt;
                    cnt <= cnt - 1'b1;
                end else if (state == S_WIN1 || state == S_WIN2) begin
                    cnt <= cnt_inc;
                end
            end else begin
                if (state == S_TITLE && start_rise) begin
                    pend_start <= 1'b1;
                end
                if (state == S_PLAY) begin
                    if (p1_win) begin
                        pend_w1 <= 1'b1;
                    end else if (p2_win) begin
                        pend_w2 <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_screen_sequencer.sv
// Testbench for screen_sequencer: directed scenarios plus randomized traffic
// checked against a frame-level behavioural model (default and zero-blank builds).
module tb_screen_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       start_btn;
    logic       p1_win;
    logic       p2_win;
    logic       abort;
    logic [1:0] sel4;
    logic       blank4;
    logic       act4;
    logic [1:0] sel0;
    logic       blank0;
    logic       act0;

    int checks = 0;
    int errors = 0;
    bit b0_seen = 1'b0;

    always #5 clk = ~clk;

    screen_sequencer #(.BLANK_FRAMES(4), .HOLD_FRAMES(180), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .start_btn(start_btn), .p1_win(p1_win), .p2_win(p2_win),
        .abort(abort), .screen_sel(sel4), .blank(blank4),
        .game_active(act4)
    );

    screen_sequencer #(.BLANK_FRAMES(0), .HOLD_FRAMES(3), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .start_btn(start_btn), .p1_win(p1_win), .p2_win(p2_win),
        .abort(abort), .screen_sel(sel0), .blank(blank0),
        .game_active(act0)
    );

    // scr: 0 title, 1 p1 win, 2 p2 win, 3 play; bl = blank frames left
    typedef struct {
        int scr;
        int bl;
        int tgt;
        int hold;
        bit ps;
        bit pw1;
        bit pw2;
        bit stq;
    } mdl_t;

    mdl_t m4;
    mdl_t m0;

    function automatic mdl_t mstep(mdl_t m, bit fs, bit st, bit w1,
                                   bit w2, bit ab, int bf, int hf);
        bit rise;
        bit title;
        bit play;
        bit es;
        bit e1;
        bit e2;
        int go;
        rise  = st && !m.stq;
        title = (m.scr == 0) && (m.bl == 0);
        play  = (m.scr == 3) && (m.bl == 0);
        es    = m.ps || (rise && title);
        e1    = m.pw1 || (w1 && play);
        e2    = m.pw2 || (w2 && play);
        m.stq = st;
        go    = -1;
        if (!fs) begin
            if (rise && title) m.ps = 1'b1;
            if (play && w1) m.pw1 = 1'b1;
            else if (play && w2) m.pw2 = 1'b1;
            return m;
        end
        m.ps  = 1'b0;
        m.pw1 = 1'b0;
        m.pw2 = 1'b0;
        if (m.bl > 0) begin
            if (ab) m.tgt = 0;
            m.bl--;
            if (m.bl == 0) begin
                m.scr  = m.tgt;
                m.hold = 0;
            end
        end else if (ab && m.scr != 0) begin
            go = 0;
        end else if (m.scr == 0) begin
            if (es) go = 3;
        end else if (m.scr == 3) begin
            if (e1) go = 1;
            else if (e2) go = 2;
        end else begin
            m.hold++;
            if (m.hold == hf) go = 0;
        end
        if (go >= 0) begin
            if (bf == 0) begin
                m.scr  = go;
                m.hold = 0;
            end else begin
                m.bl  = bf;
                m.tgt = go;
            end
        end
        return m;
    endfunction

    task automatic model_reset();
        m4 = '{default: 0};
        m0 = '{default: 0};
    endtask

    task automatic do_reset();
        frame_start = 1'b0;
        start_btn   = 1'b0;
        p1_win      = 1'b0;
        p2_win      = 1'b0;
        abort       = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input bit fs, input bit st, input bit w1,
                        input bit w2, input bit ab);
        @(negedge clk);
        frame_start = fs;
        start_btn   = st;
        p1_win      = w1;
        p2_win      = w2;
        abort       = ab;
        @(posedge clk);
        m4 = mstep(m4, fs, st, w1, w2, ab, 4, 180);
        m0 = mstep(m0, fs, st, w1, w2, ab, 0, 3);
        #1;
        if (blank0) b0_seen = 1'b1;
    endtask

    task automatic frame(input bit st, input bit ab);
        step(1'b1, st, 1'b0, 1'b0, ab);
        repeat (3) step(1'b0, st, 1'b0, 1'b0, ab);
    endtask

    task automatic go_play();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) frame(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (sel4 !== 2'b00) begin
            errors++;
            $display("FAIL reset_sel got %b want 00", sel4);
        end
        checks++;
        if (blank4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_blank got %b want 0", blank4);
        end
        checks++;
        if (act4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_active got %b want 0", act4);
        end
    endtask

    task automatic test_start();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            frame(1'b0, 1'b0);
            checks++;
            if (blank4 !== 1'b1 || sel4 !== 2'b00) begin
                errors++;
                $display("FAIL start_blank%0d got b=%b s=%b want b=1 s=00",
                         k, blank4, sel4);
            end
        end
        frame(1'b0, 1'b0);
        checks++;
        if (sel4 !== 2'b11 || blank4 !== 1'b0 || act4 !== 1'b1) begin
            errors++;
            $display("FAIL start_play got s=%b b=%b a=%b want 11 0 1",
                     sel4, blank4, act4);
        end
    endtask

    task automatic test_sim_wins();
        int fb;
        int ft;
        fb = -1;
        ft = -1;
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (5) frame(1'b0, 1'b0);
        checks++;
        if (sel4 !== 2'b01 || blank4 !== 1'b0) begin
            errors++;
            $display("FAIL simwin_sel got s=%b b=%b want 01 0", sel4, blank4);
        end
        for (int n = 1; n <= 200 && ft < 0; n++) begin
            frame(1'b0, 1'b0);
            if (blank4 && fb < 0) fb = n;
            if (sel4 == 2'b00 && !blank4) ft = n;
        end
        checks++;
        if (fb != 180) begin
            errors++;
            $display("FAIL hold_blank_frame got %0d want 180", fb);
        end
        checks++;
        if (ft != 184) begin
            errors++;
            $display("FAIL hold_title_frame got %0d want 184", ft);
        end
    endtask

    task automatic test_abort_win2();
        go_play();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) frame(1'b0, 1'b0);
        checks++;
        if (sel4 !== 2'b10) begin
            errors++;
            $display("FAIL win2_sel got %b want 10", sel4);
        end
        repeat (49) frame(1'b1, 1'b0);
        frame(1'b1, 1'b1);
        checks++;
        if (blank4 !== 1'b1 || sel4 !== 2'b10) begin
            errors++;
            $display("FAIL abort_blank got b=%b s=%b want 1 10", blank4, sel4);
        end
        repeat (4) frame(1'b1, 1'b0);
        checks++;
        if (sel4 !== 2'b00 || blank4 !== 1'b0) begin
            errors++;
            $display("FAIL abort_title got s=%b b=%b want 00 0", sel4, blank4);
        end
        repeat (10) frame(1'b1, 1'b0);
        checks++;
        if (sel4 !== 2'b00 || blank4 !== 1'b0 || act4 !== 1'b0) begin
            errors++;
            $display("FAIL held_start got s=%b b=%b a=%b want 00 0 0",
                     sel4, blank4, act4);
        end
    endtask

    task automatic test_event_on_fs();
        go_play();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        checks++;
        if (sel4 !== 2'b11 || blank4 !== 1'b0 || act4 !== 1'b1) begin
            errors++;
            $display("FAIL play_start_edge got s=%b b=%b a=%b want 11 0 1",
                     sel4, blank4, act4);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (blank4 !== 1'b1 || act4 !== 1'b0) begin
            errors++;
            $display("FAIL fs_event got b=%b a=%b want 1 0", blank4, act4);
        end
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) frame(1'b0, 1'b0);
        checks++;
        if (sel4 !== 2'b10 || blank4 !== 1'b0) begin
            errors++;
            $display("FAIL fs_event_sel got s=%b b=%b want 10 0", sel4, blank4);
        end
    endtask

    task automatic test_reset_mid_blank();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        checks++;
        if (blank4 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_blank got %b want 1", blank4);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (sel4 !== 2'b00 || blank4 !== 1'b0 || act4 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got s=%b b=%b a=%b want 00 0 0",
                     sel4, blank4, act4);
        end
        do_reset();
    endtask

    task automatic test_bf0();
        b0_seen = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (sel0 !== 2'b11 || act0 !== 1'b1) begin
            errors++;
            $display("FAIL bf0_play got s=%b a=%b want 11 1", sel0, act0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (sel0 !== 2'b01) begin
            errors++;
            $display("FAIL bf0_win got %b want 01", sel0);
        end
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        checks++;
        if (sel0 !== 2'b01) begin
            errors++;
            $display("FAIL bf0_hold got %b want 01", sel0);
        end
        frame(1'b0, 1'b0);
        checks++;
        if (sel0 !== 2'b00) begin
            errors++;
            $display("FAIL bf0_timeout got %b want 00", sel0);
        end
        checks++;
        if (b0_seen) begin
            errors++;
            $display("FAIL bf0_blank got 1 want 0");
        end
    endtask

    task automatic test_random();
        bit st;
        bit fs;
        bit w1;
        bit w2;
        bit ab;
        st = 1'b0;
        do_reset();
        b0_seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            fs = ($urandom % 4) == 0;
            if (($urandom % 8) == 0) st = ~st;
            w1 = ($urandom % 12) == 0;
            w2 = ($urandom % 12) == 0;
            ab = ($urandom % 40) == 0;
            step(fs, st, w1, w2, ab);
            checks++;
            if (sel4 !== 2'(m4.scr) || blank4 !== (m4.bl > 0) ||
                act4 !== (m4.scr == 3 && m4.bl == 0)) begin
                errors++;
                $display("FAIL rand4 @%0d got %b%b%b want %b%b%b", i,
                         sel4, blank4, act4, 2'(m4.scr), m4.bl > 0,
                         m4.scr == 3 && m4.bl == 0);
            end
            checks++;
            if (sel0 !== 2'(m0.scr) || blank0 !== 1'b0 ||
                act0 !== (m0.scr == 3)) begin
                errors++;
                $display("FAIL rand0 @%0d got %b%b%b want %b0%b", i,
                         sel0, blank0, act0, 2'(m0.scr), m0.scr == 3);
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start();
        test_sim_wins();
        test_abort_win2();
        test_event_on_fs();
        test_reset_mid_blank();
        test_bf0();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
